// File: rtl/axi_lite_master_bridge.sv
// Bridges the dot-product FSM's level-held read/write requests onto a single
// outstanding AXI4-Lite master transaction, with a sticky error status flag.
module axi_lite_master_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_req,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_data_valid,
  input  logic                write_req,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   write_data,
  output logic                write_done,
  input  logic                err_clear,
  output logic                bus_err,
  output logic [1:0]          err_resp,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  output logic [2:0]          m_axi_arprot,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  output logic [2:0]          m_axi_awprot,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, RD_DONE, WR_REQ, WR_RESP, WR_DONE
  } state_t;

  state_t     state, state_nxt;
  logic       aw_done, w_done;
  logic       ar_hs, aw_hs, w_hs;
  logic       err_hit;
  logic [1:0] err_code;

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;

  assign m_axi_arprot = '0;
  assign m_axi_awprot = '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (write_req)     state_nxt = WR_REQ;
        else if (read_req) state_nxt = RD_ADDR;
      end
      RD_ADDR: if (ar_hs)         state_nxt = RD_DATA;
      RD_DATA: if (m_axi_rvalid)  state_nxt = RD_DONE;
      RD_DONE:                    state_nxt = IDLE;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (m_axi_bvalid)  state_nxt = WR_DONE;
      WR_DONE:                    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake/pulse outputs are pure decodes of registered state, so no AXI
  // input reaches an output combinationally.
  always_comb begin
    m_axi_arvalid   = (state == RD_ADDR);
    m_axi_rready    = (state == RD_DATA);
    m_axi_awvalid   = (state == WR_REQ) && !aw_done;
    m_axi_wvalid    = (state == WR_REQ) && !w_done;
    m_axi_bready    = (state == WR_RESP);
    read_data_valid = (state == RD_DONE);
    write_done      = (state == WR_DONE);
  end

  always_comb begin
    err_hit  = 1'b0;
    err_code = m_axi_bresp;
    if (state == RD_DATA && m_axi_rvalid && m_axi_rresp != 2'b00) begin
      err_hit  = 1'b1;
      err_code = m_axi_rresp;
    end else if (state == WR_RESP && m_axi_bvalid && m_axi_bresp != 2'b00) begin
      err_hit  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
      read_data    <= '0;
      bus_err      <= 1'b0;
      err_resp     <= '0;
    end else begin
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (write_req) begin
          m_axi_awaddr <= write_addr;
          m_axi_wdata  <= write_data;
          m_axi_wstrb  <= '1;
        end else if (read_req) begin
          m_axi_araddr <= read_addr;
        end
      end
      if (state == WR_REQ) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state == RD_DATA && m_axi_rvalid) read_data <= m_axi_rdata;
      // A new error beats a simultaneous clear and reloads the code.
      if (err_hit) begin
        bus_err <= 1'b1;
        if (!bus_err || err_clear) err_resp <= err_code;
      end else if (err_clear) begin
        bus_err  <= 1'b0;
        err_resp <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge: requester stimulus, a small
// AXI4-Lite slave with programmable wait states, and protocol monitors.
module tb_axi_lite_master_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_req, write_req, err_clear;
  logic [31:0] read_addr, write_addr, write_data;
  logic [31:0] read_data;
  logic        read_data_valid, write_done, bus_err;
  logic [1:0]  err_resp;
  logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic [2:0]  m_axi_arprot, m_axi_awprot;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic [3:0]  m_axi_wstrb;

  always #5 clk = ~clk;

  axi_lite_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .read_req(read_req), .read_addr(read_addr), .read_data(read_data),
    .read_data_valid(read_data_valid),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .write_done(write_done),
    .err_clear(err_clear), .bus_err(bus_err), .err_resp(err_resp),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arprot(m_axi_arprot), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awprot(m_axi_awprot), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  // ---------------- slave model ----------------
  int unsigned ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
  int unsigned ar_wait, aw_wait, w_wait, r_wait;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic        r_pending, b_pending, aw_got, w_got;
  logic [31:0] r_data_q;
  logic [31:0] ar_log[$], aw_log[$], w_log[$];
  logic [3:0]  last_wstrb;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'hDEAD_BEEF;
      32'h0000_2000: return 32'hCAFE_0001;
      default:       return a ^ 32'h5555_AAAA;
    endcase
  endfunction

  assign m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
  assign m_axi_wready  = m_axi_wvalid  && (w_wait  >= w_delay);
  assign m_axi_rvalid  = r_pending && (r_wait >= r_delay);
  assign m_axi_rdata   = r_data_q;
  assign m_axi_rresp   = rresp_cfg;
  assign m_axi_bvalid  = b_pending;
  assign m_axi_bresp   = bresp_cfg;

  always @(posedge clk) begin
    if (reset) begin
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0; r_wait <= 0;
      r_pending <= 1'b0; b_pending <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      r_data_q <= '0;
    end else begin
      if (m_axi_arvalid && !m_axi_arready) ar_wait <= ar_wait + 1;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_wait <= 0; r_wait <= 0; r_pending <= 1'b1;
        r_data_q <= mem_f(m_axi_araddr);
        ar_log.push_back(m_axi_araddr);
      end
      if (r_pending && !m_axi_rvalid) r_wait <= r_wait + 1;
      if (m_axi_rvalid && m_axi_rready) r_pending <= 1'b0;
      if (m_axi_awvalid && !m_axi_awready) aw_wait <= aw_wait + 1;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_wait <= 0; aw_log.push_back(m_axi_awaddr);
      end
      if (m_axi_wvalid && !m_axi_wready) w_wait <= w_wait + 1;
      if (m_axi_wvalid && m_axi_wready) begin
        w_wait <= 0; w_log.push_back(m_axi_wdata); last_wstrb <= m_axi_wstrb;
      end
      if ((aw_got || (m_axi_awvalid && m_axi_awready)) &&
          (w_got  || (m_axi_wvalid  && m_axi_wready))) begin
        b_pending <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_got <= 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_got  <= 1'b1;
      end
      if (m_axi_bvalid && m_axi_bready) b_pending <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int unsigned awv_cyc, wv_cyc, bready_cyc, rdv_cnt, wd_cnt, viol;
  logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_araddr, p_awaddr, p_wdata;

  initial begin
    awv_cyc = 0; wv_cyc = 0; bready_cyc = 0; rdv_cnt = 0; wd_cnt = 0; viol = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      p_arv = 1'b0; p_awv = 1'b0; p_wv = 1'b0;
      p_arr = 1'b0; p_awr = 1'b0; p_wr = 1'b0;
    end else begin
      if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
      if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
      if (p_wv  && !p_wr  && (!m_axi_wvalid  || m_axi_wdata  != p_wdata))  viol++;
      if (m_axi_awvalid)   awv_cyc++;
      if (m_axi_wvalid)    wv_cyc++;
      if (m_axi_bready)    bready_cyc++;
      if (read_data_valid) rdv_cnt++;
      if (write_done)      wd_cnt++;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wdata  = m_axi_wdata;
    end
  end

  // ---------------- checking ----------------
  int unsigned n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0. Each request is
  // dropped on the edge that ends its completion pulse.
  task automatic run_txn(input logic do_wr, input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic do_rd, input logic [31:0] raddr,
                         output int wr_cyc, output int rd_cyc, output logic [31:0] rdata_o);
    wr_cyc = -1; rd_cyc = -1; rdata_o = '0;
    write_req = do_wr; write_addr = waddr; write_data = wdata;
    read_req = do_rd;  read_addr = raddr;
    for (int c = 0; c < 60 && (write_req || read_req); c++) begin
      @(negedge clk);
      if (write_done)      wr_cyc = c;
      if (read_data_valid) begin rd_cyc = c; rdata_o = read_data; end
      @(posedge clk); #1;
      if (wr_cyc >= 0) write_req = 1'b0;
      if (rd_cyc >= 0) read_req  = 1'b0;
    end
    write_req = 1'b0; read_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          wc, rc;
  logic [31:0] rd;
  int unsigned ar0, aw0, w0, awv0, wv0, br0, rdv0, wd0;
  int          pc[2];
  logic [31:0] pd[2];
  int          np;

  initial begin
    reset = 1'b1; read_req = 0; write_req = 0; err_clear = 0;
    read_addr = '0; write_addr = '0; write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_read_data", read_data, 0);
    check_eq("rst_pulses", {read_data_valid, write_done}, 0);
    check_eq("rst_err", {bus_err, err_resp}, 0);
    check_eq("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    check_eq("rst_addrs", {m_axi_araddr, m_axi_awaddr}, 0);
    check_eq("rst_wdata", m_axi_wdata, 0);
    @(posedge clk); #1; reset = 1'b0;

    // single read, zero-wait slave
    rdv0 = rdv_cnt;
    run_txn(1'b0, '0, '0, 1'b1, 32'h1000, wc, rc, rd);
    check_eq("rd1_latency", rc, 3);
    check_eq("rd1_data", rd, 32'hDEAD_BEEF);
    check_eq("rd1_araddr", ar_log[ar_log.size()-1], 32'h1000);
    check_eq("rd1_pulses", rdv_cnt - rdv0, 1);
    check_eq("rd1_bus_err", bus_err, 0);
    check_eq("rd1_prot", {m_axi_arprot, m_axi_awprot}, 0);

    // held read_req, address switched on the pulse edge, arready 2 cycles late
    ar_delay = 2; ar0 = ar_log.size(); rdv0 = rdv_cnt; np = 0;
    read_req = 1'b1; read_addr = 32'h1000;
    for (int c = 0; c < 80 && read_req; c++) begin
      @(negedge clk);
      if (read_data_valid && np < 2) begin pc[np] = c; pd[np] = read_data; np++; end
      @(posedge clk); #1;
      if (np == 1) read_addr = 32'h2000;
      if (np == 2) read_req = 1'b0;
    end
    read_req = 1'b0; ar_delay = 0;
    idle_cycles(6);
    check_eq("rd2_count", np, 2);
    check_eq("rd2_pulse_cycles", {pc[0], pc[1]}, {32'd5, 32'd11});
    check_eq("rd2_data", {pd[0], pd[1]}, {32'hDEAD_BEEF, 32'hCAFE_0001});
    check_eq("rd2_ar_count", ar_log.size() - ar0, 2);
    check_eq("rd2_ar_addrs", {ar_log[ar0], ar_log[ar0+1]}, {32'h1000, 32'h2000});
    check_eq("rd2_pulses", rdv_cnt - rdv0, 2);

    // write, W handshake 3 cycles ahead of AW
    aw_delay = 3; aw0 = aw_log.size(); w0 = w_log.size();
    awv0 = awv_cyc; wv0 = wv_cyc; br0 = bready_cyc; wd0 = wd_cnt;
    run_txn(1'b1, 32'h3000, 32'h0000_0040, 1'b0, '0, wc, rc, rd);
    aw_delay = 0;
    idle_cycles(5);
    check_eq("wr1_latency", wc, 6);
    check_eq("wr1_awvalid_cycles", awv_cyc - awv0, 4);
    check_eq("wr1_wvalid_cycles", wv_cyc - wv0, 1);
    check_eq("wr1_bready_cycles", bready_cyc - br0, 1);
    check_eq("wr1_aw_count", aw_log.size() - aw0, 1);
    check_eq("wr1_w_count", w_log.size() - w0, 1);
    check_eq("wr1_awaddr", aw_log[aw_log.size()-1], 32'h3000);
    check_eq("wr1_wdata", w_log[w_log.size()-1], 32'h40);
    check_eq("wr1_wstrb", last_wstrb, 4'hF);
    check_eq("wr1_pulses", wd_cnt - wd0, 1);

    // simultaneous requests: write first, then read
    run_txn(1'b1, 32'h5000, 32'h1234, 1'b1, 32'h4000, wc, rc, rd);
    check_eq("both_wr_cycle", wc, 3);
    check_eq("both_rd_cycle", rc, 7);
    check_eq("both_rd_data", rd, 32'h5555_EAAA);
    check_eq("both_addrs", {aw_log[aw_log.size()-1], ar_log[ar_log.size()-1]}, {32'h5000, 32'h4000});
    check_eq("both_wdata", w_log[w_log.size()-1], 32'h1234);

    // error capture: first error code is kept
    bresp_cfg = 2'b10;
    run_txn(1'b1, 32'h6000, 32'h77, 1'b0, '0, wc, rc, rd);
    bresp_cfg = 2'b00;
    check_eq("berr_done_cycle", wc, 3);
    check_eq("berr_flags", {bus_err, err_resp}, 3'b110);
    rresp_cfg = 2'b11;
    run_txn(1'b0, '0, '0, 1'b1, 32'h1000, wc, rc, rd);
    check_eq("rerr_data", {rc, rd}, {32'd3, 32'hDEAD_BEEF});
    check_eq("rerr_flags_kept", {bus_err, err_resp}, 3'b110);

    // err_clear coinciding with a new error: set wins with the new code
    rresp_cfg = 2'b01;
    read_req = 1'b1; read_addr = 32'h2000;
    @(posedge clk); #1;
    @(posedge clk); #1; err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
    @(negedge clk);
    check_eq("clrhit_pulse_data", {read_data_valid, read_data}, {1'b1, 32'hCAFE_0001});
    check_eq("clrhit_flags", {bus_err, err_resp}, 3'b101);
    @(posedge clk); #1; read_req = 1'b0; rresp_cfg = 2'b00;
    idle_cycles(2);
    err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
    @(negedge clk);
    check_eq("clr_flags", {bus_err, err_resp}, 0);
    @(posedge clk); #1;

    // reset while waiting in RD_DATA
    r_delay = 5;
    read_req = 1'b1; read_addr = 32'h2000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid_rready_before", m_axi_rready, 1);
    @(posedge clk); #1; reset = 1'b1; read_req = 1'b0;
    @(posedge clk); #1; reset = 1'b0; r_delay = 0;
    @(negedge clk);
    check_eq("mid_valids", {m_axi_rready, m_axi_arvalid, read_data_valid, write_done}, 0);
    check_eq("mid_read_data", read_data, 0);
    check_eq("mid_araddr", m_axi_araddr, 0);
    @(posedge clk); #1;
    run_txn(1'b0, '0, '0, 1'b1, 32'h1000, wc, rc, rd);
    check_eq("post_rst_read", {rc, rd}, {32'd3, 32'hDEAD_BEEF});
    check_eq("protocol_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_bridge.md
# axi_lite_master_bridge

Converts the dot-product FSM's level-held memory request interface (read_req/read_addr → read_data/read_data_valid, write_req/write_addr/write_data → write_done) into single-beat AXI4-Lite master transactions. It sits directly downstream of the dot-product FSM and drives the accelerator's AXI4-Lite master port toward system memory. One transaction is outstanding at a time. Error responses are captured in a sticky status flag.

## Interface
- ADDR_W, 32, AXI and request address width
- DATA_W, 32, data width; wstrb is DATA_W/8 bits
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- read_req  in  1  level request; held until read_data_valid
- read_addr  in  ADDR_W  read address; sampled when the request is accepted
- read_data  out  DATA_W  returned data; valid while read_data_valid=1
- read_data_valid  out  1  one-cycle completion pulse
- write_req  in  1  level request; held until write_done
- write_addr  in  ADDR_W  write address; sampled on accept
- write_data  in  DATA_W  write data; sampled on accept
- write_done  out  1  one-cycle completion pulse
- err_clear  in  1  clears bus_err and err_resp
- bus_err  out  1  sticky; set by any non-OKAY RRESP or BRESP
- err_resp  out  2  response code of the first error since the last clear
- m_axi_araddr/arvalid/arprot  out  ADDR_W/1/3, with m_axi_arready  in  1
- m_axi_rdata/rresp/rvalid  in  DATA_W/2/1, with m_axi_rready  out  1
- m_axi_awaddr/awvalid/awprot  out  ADDR_W/1/3, with m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  DATA_W/DATA_W/8/1, with m_axi_wready  in  1
- m_axi_bresp/bvalid  in  2/1, with m_axi_bready  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, RD_DONE, WR_REQ, WR_RESP, WR_DONE.
- IDLE behaviour:
  - Samples the requests. write_req wins when both are high; read_req is then served after the write completes.
  - On accept, latches address (and data for writes) into output registers.
  - Read accept → RD_ADDR; write accept → WR_REQ.
- Read sequence:
  - RD_ADDR: arvalid=1 until the arvalid&arready cycle, then → RD_DATA.
  - RD_DATA: rready=1; on rvalid, capture rdata into read_data and check rresp, → RD_DONE.
  - RD_DONE: read_data_valid=1 for one cycle, → IDLE.
- Write sequence:
  - WR_REQ: awvalid and wvalid both rise on entry. Each drops independently the cycle after its own handshake. Either handshake may happen first or both together.
  - When both handshakes are complete → WR_RESP.
  - WR_RESP: bready=1; on bvalid, check bresp, → WR_DONE.
  - WR_DONE: write_done=1 for one cycle, → IDLE.
- IDLE never samples in a pulse cycle. The requester updates read_req/read_addr on the pulse edge, so IDLE sees the next request one cycle after the pulse. A request held continuously (read A then read B) is therefore handled correctly.
- Constant outputs: arprot=awprot=3'b000; wstrb all ones.
- read_data holds its last captured value until the next read completes. It is not cleared after the pulse.
- Error handling:
  - Any resp≠2'b00 sets bus_err; err_resp is loaded only if bus_err was 0.
  - Data is still returned and the done pulse is still issued; there is no retry.
  - If err_clear coincides with a new error, the set wins and err_resp takes the new code.
- Reset mid-transaction: the state machine returns to IDLE on the next edge and all valid/ready outputs and pulses drop. Shared reset with the slave is assumed by the system; no transaction is resumed.

## Timing
- Reset values: every output 0, including read_data, all AXI address/data outputs, bus_err and err_resp.
- All outputs are registered; there is no combinational path from AXI inputs to outputs.
- Read latency, request high in cycle 0:
  - arvalid in cycle 1; with arready=1, handshake in cycle 1.
  - rready in cycle 2; if rvalid=1, read_data_valid in cycle 3.
  - Minimum 3 cycles; each slave wait cycle adds one.
- Write latency, request high in cycle 0:
  - aw/wvalid in cycle 1; both handshakes in cycle 1.
  - bready in cycle 2; if bvalid, write_done in cycle 3.
  - Minimum 3 cycles.
- Back-to-back: the next accept occurs at the earliest one cycle after a done pulse, giving a 4-cycle minimum period per transaction.
- arvalid/awvalid/wvalid never deassert before their handshake, and the address/data outputs stay stable while the corresponding valid is high.

## Test plan
- Single read, addr 0x1000, slave returns 0xDEADBEEF with zero wait → araddr=0x1000, read_data=0xDEADBEEF, read_data_valid one cycle at cycle 3, bus_err=0.
- Held read_req with addr switching 0x1000→0x2000 in the pulse cycle, slave arready delayed 2 cycles → two AR transactions in order with the correct addresses, two pulses, no extra read issued.
- Write 0x0000_0040 to 0x3000:
  - wready 3 cycles before awready → each valid drops right after its own handshake, one bready phase, write_done one cycle, no duplicate write while write_req is still high in the pulse cycle.
- read_req and write_req high together in IDLE → the write completes first, then the read, each with one pulse.
- BRESP=2'b10, then RRESP=2'b11 → bus_err=1 and err_resp=2'b10 (first error kept); err_clear → both 0.
- reset asserted while in RD_DATA → next cycle rready=0, state IDLE, all outputs at reset values; a fresh read after reset completes normally.
